// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the LC-3b hazard/forwarding controller: register numbers,
// forwarding-select encoding and the per-stage write-back shadow fields.
// Pure type/constant package; no logic, no latency, no flow control.
package hazard_forward_unit_pkg;

    typedef logic [2:0] lc3b_reg;

    // Operand source feeding the execute stage.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,    // register file read
        FWD_WB  = 2'b01,    // write_data from WB
        FWD_MEM = 2'b10     // alu_ex_mem_out from MEM
    } lc3b_fwd_sel;

    // What a downstream stage will write back, as far as hazards care.
    typedef struct packed {
        lc3b_reg dest;
        logic    regwrite;
        logic    is_load;
    } lc3b_hz_fields;

    // Register-usage shadow of the instruction sitting in EX.
    typedef struct packed {
        logic          valid;
        lc3b_reg       sr1;
        lc3b_reg       sr2;
        logic          uses_sr1;
        logic          uses_sr2;
        logic          uses_dest_src;
        lc3b_hz_fields wr;
    } lc3b_ex_shadow;

    localparam lc3b_hz_fields HZ_BUBBLE = '{dest: 3'd0, regwrite: 1'b0, is_load: 1'b0};
    localparam lc3b_ex_shadow EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Bundle between the LC-3b pipeline (master) and the hazard unit (slave).
// Carries decode-stage register usage in, forwarding selects / stalls out.
// No flow control of its own; stalls are expressed by the stall_* signals.
interface hazard_forward_unit_if #(parameter int CNT_W = 16);
    import hazard_forward_unit_pkg::*;

    // decode stage -> hazard unit
    logic             id_valid;
    lc3b_reg          id_sr1;
    lc3b_reg          id_sr2;
    logic             id_uses_sr1;
    logic             id_uses_sr2;
    logic             id_uses_dest_src;
    lc3b_reg          id_dest;
    logic             id_regwrite;
    logic             id_is_load;
    logic             flush;
    logic             mem_busy;

    // hazard unit -> pipeline control
    logic [1:0]       sr1_forward_sel;
    logic [1:0]       sr2_forward_sel;
    logic             dest_forward_sel;
    logic             stall_front;
    logic             stall_ex;
    logic             bubble_mem;
    logic             freeze;
    logic [CNT_W-1:0] hazard_stalls;

    modport master (
        output id_valid, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
               id_uses_dest_src, id_dest, id_regwrite, id_is_load,
               flush, mem_busy,
        input  sr1_forward_sel, sr2_forward_sel, dest_forward_sel,
               stall_front, stall_ex, bubble_mem, freeze, hazard_stalls
    );

    modport slave (
        input  id_valid, id_sr1, id_sr2, id_uses_sr1, id_uses_sr2,
               id_uses_dest_src, id_dest, id_regwrite, id_is_load,
               flush, mem_busy,
        output sr1_forward_sel, sr2_forward_sel, dest_forward_sel,
               stall_front, stall_ex, bubble_mem, freeze, hazard_stalls
    );

endinterface

// File: rtl/hazard_forward_unit_fwd_match.sv
// Finds the newest in-flight producer (MEM before WB) of one EX source register.
// Purely combinational, zero latency.
// No flow control; the caller decides whether a MEM match is usable.
// Ports: src_used/src = the EX source, mem_f/wb_f = downstream write shadows,
//        sel = where the value lives, mem_is_load = MEM match is a load result.
module fwd_match
    import hazard_forward_unit_pkg::*;
(
    input  logic          src_used,
    input  lc3b_reg       src,
    input  lc3b_hz_fields mem_f,
    input  lc3b_hz_fields wb_f,
    output lc3b_fwd_sel   sel,
    output logic          mem_is_load
);

    always_comb begin
        sel         = FWD_REG;
        mem_is_load = 1'b0;
        if (src_used) begin
            // MEM holds the younger write, so it shadows WB. R0 is an ordinary register.
            if (mem_f.regwrite && (mem_f.dest == src)) begin
                sel         = FWD_MEM;
                mem_is_load = mem_f.is_load;
            end else if (wb_f.regwrite && (wb_f.dest == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// LC-3b hazard/forwarding controller: EX operand selects plus load-use and store-data stalls.
// Selects/stalls are combinational from the shadows; each uncoverable hazard costs 1 stall cycle.
// mem_busy freezes every shadow and masks all stall outputs; hz holds EX and bubbles MEM.
// Ports: clk, rst_n (async, active low), bus (slave modport): id_* decode fields,
//        flush, mem_busy in; sr1/sr2/dest forward selects, stall_front, stall_ex,
//        bubble_mem, freeze, hazard_stalls out.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_forward_unit_if.slave  bus
);

    lc3b_ex_shadow    ex_q;
    lc3b_ex_shadow    ex_next;
    lc3b_hz_fields    mem_q;
    lc3b_hz_fields    wb_q;
    logic [CNT_W-1:0] stall_cnt_q;

    lc3b_fwd_sel      sr1_match;
    lc3b_fwd_sel      sr2_match;
    lc3b_fwd_sel      dest_match;
    logic             sr1_mem_load;
    logic             sr2_mem_load;
    logic             dest_mem_load;
    logic             sr1_hz;
    logic             sr2_hz;
    logic             dest_hz;
    logic             hz;
    logic             freeze;
    logic             hz_stall;

    fwd_match u_sr1_match (
        .src_used    (ex_q.valid & ex_q.uses_sr1),
        .src         (ex_q.sr1),
        .mem_f       (mem_q),
        .wb_f        (wb_q),
        .sel         (sr1_match),
        .mem_is_load (sr1_mem_load)
    );

    fwd_match u_sr2_match (
        .src_used    (ex_q.valid & ex_q.uses_sr2),
        .src         (ex_q.sr2),
        .mem_f       (mem_q),
        .wb_f        (wb_q),
        .sel         (sr2_match),
        .mem_is_load (sr2_mem_load)
    );

    fwd_match u_dest_match (
        .src_used    (ex_q.valid & ex_q.uses_dest_src),
        .src         (ex_q.wr.dest),
        .mem_f       (mem_q),
        .wb_f        (wb_q),
        .sel         (dest_match),
        .mem_is_load (dest_mem_load)
    );

    // A load result in MEM is not on alu_ex_mem_out yet, so it must wait a cycle.
    assign sr1_hz  = (sr1_match == FWD_MEM) & sr1_mem_load;
    assign sr2_hz  = (sr2_match == FWD_MEM) & sr2_mem_load;
    // Store data has no MEM forwarding path at all; any MEM producer stalls.
    // The load flag only ever accompanies a MEM match, so OR-ing it in is harmless.
    assign dest_hz = (dest_match == FWD_MEM) | dest_mem_load;
    assign hz      = sr1_hz | sr2_hz | dest_hz;

    assign freeze   = bus.mem_busy;
    assign hz_stall = hz & ~freeze;

    always_comb begin
        bus.sr1_forward_sel  = sr1_hz ? FWD_REG : sr1_match;
        bus.sr2_forward_sel  = sr2_hz ? FWD_REG : sr2_match;
        bus.dest_forward_sel = (dest_match == FWD_WB);
    end

    assign bus.stall_front   = hz_stall;
    assign bus.stall_ex      = hz_stall;
    assign bus.bubble_mem    = hz_stall;
    assign bus.freeze        = freeze;
    assign bus.hazard_stalls = stall_cnt_q;

    // Squashed or empty decode slots enter EX as a bubble that writes nothing.
    always_comb begin
        ex_next               = EX_BUBBLE;
        if (bus.id_valid && !bus.flush) begin
            ex_next.valid         = 1'b1;
            ex_next.sr1           = bus.id_sr1;
            ex_next.sr2           = bus.id_sr2;
            ex_next.uses_sr1      = bus.id_uses_sr1;
            ex_next.uses_sr2      = bus.id_uses_sr2;
            ex_next.uses_dest_src = bus.id_uses_dest_src;
            ex_next.wr.dest       = bus.id_dest;
            ex_next.wr.regwrite   = bus.id_regwrite;
            ex_next.wr.is_load    = bus.id_is_load;
        end
    end

    // During a hazard stall flush is ignored: EX keeps its instruction and the
    // branch unit re-issues flush once the stall clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= EX_BUBBLE;
            mem_q       <= HZ_BUBBLE;
            wb_q        <= HZ_BUBBLE;
            stall_cnt_q <= '0;
        end else if (!freeze) begin
            wb_q <= mem_q;
            if (hz) begin
                mem_q <= HZ_BUBBLE;
                if (stall_cnt_q != '1) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
            end else begin
                mem_q <= ex_q.wr;
                ex_q  <= ex_next;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed pipeline sequences and
// randomized traffic against an instruction-level model of the EX/MEM/WB pipe.
// Small counter width so saturation is reachable.
module tb_hazard_forward_unit;
    import hazard_forward_unit_pkg::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.CNT_W(CNT_W)) bus();

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Whole instructions travel through the model pipe.
    typedef struct {
        bit valid;
        int sr1;
        int sr2;
        bit u1;
        bit u2;
        bit ud;
        int dest;
        bit rw;
        bit ld;
    } instr_t;

    instr_t m_ex, m_mem, m_wb, cur;
    int     m_cnt;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t nop_i();
        instr_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic instr_t alu(input int d, input int a, input int b);
        instr_t r = nop_i();
        r.valid = 1; r.sr1 = a; r.sr2 = b; r.u1 = 1; r.u2 = 1; r.dest = d; r.rw = 1;
        return r;
    endfunction

    function automatic instr_t ldr(input int d, input int base);
        instr_t r = nop_i();
        r.valid = 1; r.sr1 = base; r.u1 = 1; r.dest = d; r.rw = 1; r.ld = 1;
        return r;
    endfunction

    function automatic instr_t str(input int src, input int base);
        instr_t r = nop_i();
        r.valid = 1; r.sr1 = base; r.u1 = 1; r.ud = 1; r.dest = src;
        return r;
    endfunction

    function automatic instr_t rand_instr();
        instr_t r;
        int a = $urandom_range(0, 3);
        int b = $urandom_range(0, 3);
        int d = $urandom_range(0, 3);
        case ($urandom_range(0, 5))
            0, 1:    r = alu(d, a, b);
            2:       r = ldr(d, a);
            3:       r = str(d, a);
            4:       begin r = alu(d, a, b); r.u2 = 0; end
            default: begin r = nop_i(); r.valid = 1; end  // branch-like, no register use
        endcase
        if ($urandom_range(0, 3) == 0) r = nop_i();
        return r;
    endfunction

    // Where does EX source r come from? Look for the newest older writer.
    // One stage ahead (MEM): only a finished ALU result feeding sr1/sr2 is reachable;
    // a load result or store data must wait. Two stages ahead (WB): always reachable.
    function automatic void src_need(input bit used, input int r, input bit store_data,
                                     output int sel, output bit stall);
        instr_t older[2];
        older[0] = m_mem;
        older[1] = m_wb;
        sel   = 0;
        stall = 0;
        if (!used) return;
        for (int k = 0; k < 2; k++) begin
            if (older[k].rw && older[k].dest == r) begin
                if (k == 1) begin
                    sel = 1;
                end else if (!older[k].ld && !store_data) begin
                    sel = 2;
                end else begin
                    stall = 1;
                end
                return;
            end
        end
    endfunction

    function automatic void model_outputs(output int s1, output int s2, output int d, output bit hz);
        bit h1, h2, hd;
        int dsel;
        src_need(m_ex.valid && m_ex.u1, m_ex.sr1, 1'b0, s1, h1);
        src_need(m_ex.valid && m_ex.u2, m_ex.sr2, 1'b0, s2, h2);
        src_need(m_ex.valid && m_ex.ud, m_ex.dest, 1'b1, dsel, hd);
        d  = dsel;
        hz = h1 | h2 | hd;
    endfunction

    task automatic model_reset();
        m_ex  = nop_i();
        m_mem = nop_i();
        m_wb  = nop_i();
        m_cnt = 0;
    endtask

    task automatic compare_all(input string ph);
        int s1, s2, d;
        bit hz, st;
        model_outputs(s1, s2, d, hz);
        st = hz && !bus.mem_busy;
        chk_eq({ph, "_sr1_sel"},  bus.sr1_forward_sel,  s1);
        chk_eq({ph, "_sr2_sel"},  bus.sr2_forward_sel,  s2);
        chk_eq({ph, "_dest_sel"}, bus.dest_forward_sel, d);
        chk_eq({ph, "_stall_front"}, bus.stall_front, st);
        chk_eq({ph, "_stall_ex"},    bus.stall_ex,    st);
        chk_eq({ph, "_bubble_mem"},  bus.bubble_mem,  st);
        chk_eq({ph, "_freeze"},      bus.freeze,      bus.mem_busy);
        chk_eq({ph, "_hazard_stalls"}, bus.hazard_stalls, m_cnt);
    endtask

    task automatic drive(input instr_t i, input bit fl, input bit busy);
        cur                  = i;
        bus.id_valid         = i.valid;
        bus.id_sr1           = 3'(i.sr1);
        bus.id_sr2           = 3'(i.sr2);
        bus.id_uses_sr1      = i.u1;
        bus.id_uses_sr2      = i.u2;
        bus.id_uses_dest_src = i.ud;
        bus.id_dest          = 3'(i.dest);
        bus.id_regwrite      = i.rw;
        bus.id_is_load       = i.ld;
        bus.flush            = fl;
        bus.mem_busy         = busy;
    endtask

    // One clock: advance the model with the inputs as driven, then check at negedge.
    task automatic cycle();
        int     s1, s2, d;
        bit     hz;
        instr_t nx_ex, nx_mem, nx_wb;
        int     nx_cnt;
        model_outputs(s1, s2, d, hz);
        nx_ex = m_ex; nx_mem = m_mem; nx_wb = m_wb; nx_cnt = m_cnt;
        if (!rst_n) begin
            nx_ex = nop_i(); nx_mem = nop_i(); nx_wb = nop_i(); nx_cnt = 0;
        end else if (!bus.mem_busy) begin
            nx_wb = m_mem;
            if (hz) begin
                nx_mem = nop_i();
                if (m_cnt < CNT_MAX) nx_cnt = m_cnt + 1;
            end else begin
                nx_mem = m_ex;
                nx_ex  = (cur.valid && !bus.flush) ? cur : nop_i();
            end
        end
        @(posedge clk);
        m_ex = nx_ex; m_mem = nx_mem; m_wb = nx_wb; m_cnt = nx_cnt;
        @(negedge clk);
        compare_all("cyc");
    endtask

    // Present an instruction in ID, hold it through any stall, then let it enter EX.
    task automatic issue(input instr_t i);
        int guard = 0;
        drive(i, 1'b0, 1'b0);
        while (bus.stall_ex === 1'b1 && guard < 8) begin
            cycle();
            guard++;
        end
        chk_eq("issue_stall_bound", bus.stall_ex, 1'b0);
        cycle();
    endtask

    // Called at a negedge: assert reset, check asynchronous clearing, release next negedge.
    task automatic hard_reset();
        rst_n = 1'b0;
        model_reset();
        #1 compare_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nxt;
        int     s1, s2, d;
        bit     hz, busy, fl;

        drive(nop_i(), 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        hard_reset();

        // ALU result in MEM feeds both sources.
        issue(alu(1, 2, 3));
        issue(alu(2, 1, 1));
        chk_eq("p1_sr1", bus.sr1_forward_sel, 2'b10);
        chk_eq("p1_sr2", bus.sr2_forward_sel, 2'b10);
        chk_eq("p1_stall", bus.stall_front, 1'b0);
        chk_eq("p1_cnt", bus.hazard_stalls, 0);

        // Producer two ahead comes from WB.
        hard_reset();
        issue(alu(1, 2, 3));
        issue(nop_i());
        issue(alu(3, 1, 4));
        chk_eq("p2_sr1", bus.sr1_forward_sel, 2'b01);
        chk_eq("p2_sr2", bus.sr2_forward_sel, 2'b00);

        // MEM wins over WB.
        hard_reset();
        issue(alu(1, 2, 3));
        issue(alu(1, 2, 3));
        issue(alu(5, 1, 0));
        chk_eq("p3_sr1", bus.sr1_forward_sel, 2'b10);
        chk_eq("p3_sr2", bus.sr2_forward_sel, 2'b00);

        // Load-use: exactly one stall, then WB forwarding.
        hard_reset();
        issue(ldr(1, 6));
        drive(alu(2, 1, 1), 1'b0, 1'b0);
        cycle();
        chk_eq("p4_stall_front", bus.stall_front, 1'b1);
        chk_eq("p4_stall_ex", bus.stall_ex, 1'b1);
        chk_eq("p4_bubble", bus.bubble_mem, 1'b1);
        chk_eq("p4_sr1_hold", bus.sr1_forward_sel, 2'b00);
        drive(nop_i(), 1'b0, 1'b0);
        cycle();
        chk_eq("p4_sr1_wb", bus.sr1_forward_sel, 2'b01);
        chk_eq("p4_sr2_wb", bus.sr2_forward_sel, 2'b01);
        chk_eq("p4_no_stall", bus.stall_front, 1'b0);
        chk_eq("p4_cnt", bus.hazard_stalls, 1);

        // Store data right after its producer: one stall, then WB.
        hard_reset();
        issue(alu(1, 2, 3));
        drive(str(1, 6), 1'b0, 1'b0);
        cycle();
        chk_eq("p5_stall", bus.stall_ex, 1'b1);
        chk_eq("p5_dest_hold", bus.dest_forward_sel, 1'b0);
        drive(nop_i(), 1'b0, 1'b0);
        cycle();
        chk_eq("p5_dest_wb", bus.dest_forward_sel, 1'b1);
        chk_eq("p5_no_stall", bus.stall_ex, 1'b0);

        // Freeze during a load-use hazard, then reset mid-freeze.
        hard_reset();
        issue(ldr(1, 6));
        drive(alu(2, 1, 1), 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            drive(alu(2, 1, 1), 1'b0, 1'b1);
            cycle();
            chk_eq("p6_freeze", bus.freeze, 1'b1);
            chk_eq("p6_stall_masked", bus.stall_front, 1'b0);
            chk_eq("p6_sel_const", bus.sr1_forward_sel, 2'b00);
            chk_eq("p6_cnt_const", bus.hazard_stalls, 0);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_eq("p6_rst_sr1", bus.sr1_forward_sel, 2'b00);
        chk_eq("p6_rst_dest", bus.dest_forward_sel, 1'b0);
        chk_eq("p6_rst_stall", bus.stall_front, 1'b0);
        chk_eq("p6_rst_freeze", bus.freeze, 1'b1);
        chk_eq("p6_rst_cnt", bus.hazard_stalls, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(nop_i(), 1'b0, 1'b0);
        cycle();
        chk_eq("p6_no_pending", bus.stall_ex, 1'b0);

        // Counter saturation.
        hard_reset();
        for (int k = 0; k < 18; k++) begin
            issue(ldr(1, 6));
            issue(alu(2, 1, 1));
        end
        issue(nop_i());
        chk_eq("sat_cnt", bus.hazard_stalls, CNT_MAX);

        // Randomized traffic with flush, freeze and occasional asynchronous reset.
        hard_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 63) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1 compare_all("rrst");
            end
            busy = ($urandom_range(0, 4) == 0);
            fl   = ($urandom_range(0, 7) == 0);
            model_outputs(s1, s2, d, hz);
            // IF/ID holds its instruction while the pipe is stalled or frozen.
            if (hz || bus.mem_busy) nxt = cur;
            else                    nxt = rand_instr();
            drive(nxt, fl, busy);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline hazard and forwarding controller for the LC-3b pipeline. Shadows the register-usage fields of the instructions in EX, MEM and WB and drives the execute stage's forwarding selects (`sr1_forward_sel`, `sr2_forward_sel`, `dest_forward_sel`). Detects hazards that forwarding cannot cover (load-use, store-data from MEM) and issues stall/bubble controls. Freezes with the rest of the pipeline on memory wait.

## Interface

Parameters:
- `CNT_W`, 16: width of the saturating hazard-stall counter.

Ports:
- `clk` in 1: single clock; everything is clocked on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the ID/EX register is being loaded with a real instruction.
- `id_sr1`, `id_sr2` in 3 (`lc3b_reg`): source register numbers of the decoding instruction.
- `id_uses_sr1`, `id_uses_sr2` in 1: the instruction reads that source.
- `id_uses_dest_src` in 1: the dest field is read as data (STR/STB/STI).
- `id_dest` in 3: destination register number.
- `id_regwrite` in 1: the instruction writes the register file.
- `id_is_load` in 1: the result comes from memory (LDR/LDB/LDI).
- `flush` in 1: taken branch or jump; squash the instruction entering EX.
- `mem_busy` in 1: the MEM-stage access is outstanding; the whole pipe freezes.
- `sr1_forward_sel`, `sr2_forward_sel` out 2: 00 register file, 01 write_data (WB), 10 alu_ex_mem_out (MEM).
- `dest_forward_sel` out 1: 0 dest_out, 1 write_data.
- `stall_front` out 1: hold PC and IF/ID.
- `stall_ex` out 1: hold ID/EX.
- `bubble_mem` out 1: load a NOP into EX/MEM.
- `freeze` out 1: equals `mem_busy`; hold all pipeline registers.
- `hazard_stalls` out `CNT_W`: number of hazard-stall cycles, saturating.

## Operation

- Shadow registers: EX holds {valid, sr1, sr2, use flags, dest, regwrite, is_load}. MEM and WB each hold {dest, regwrite, is_load}.
- Advance rule when `freeze`=0 and `hz`=0:
  - ID→EX loads the `id_*` fields. If `id_valid`=0 or `flush`=1, EX is loaded invalid with regwrite=0.
  - EX→MEM and MEM→WB copy.
- Hazard stall (`hz`=1, `freeze`=0):
  - EX holds its contents.
  - MEM loads a bubble (regwrite=0).
  - WB takes the old MEM contents.
- `freeze`=1: all shadows hold.
- Per-source match: `fwd_match` of EX source s, for s in sr1, sr2, dest-as-source, when that source is used and EX is valid:
  - If MEM.regwrite and MEM.dest==s, the result is MEM.
  - Otherwise, if WB.regwrite and WB.dest==s, the result is WB.
  - Otherwise, the result is REG.
  - MEM has priority over WB. R0 is a normal register and is not excluded.
- sr1/sr2 selects:
  - MEM match, non-load → 10.
  - WB match → 01.
  - MEM match on a load → 00 and `hz`=1.
- Dest select:
  - WB match → 1.
  - MEM match (any) → 0 and `hz`=1.
  - Reason: the execute stage has no MEM path for store data.
- Outputs:
  - `stall_front` = `stall_ex` = `bubble_mem` = `hz` & ~`freeze`.
  - `freeze` = `mem_busy`.
- Counter: `hazard_stalls` increments on each cycle with `hz` & ~`freeze`. It saturates at all-ones and never wraps.
- `flush` during `hz`: the stall wins. The instruction in EX is not squashed by this unit. The branch unit re-asserts `flush` once the stall clears.

## Timing

- Reset (async, `rst_n`=0):
  - All shadow valid/regwrite/is_load cleared.
  - Selects 00/00/0.
  - All stall outputs 0 except `freeze`, which follows `mem_busy`.
  - Counter 0.
  - Release is synchronous to `clk`.
- Selects and `hz` are combinational from the shadow registers only, so they are valid early in each cycle. There is no input-to-select path.
- A load-use hazard costs exactly 1 stall cycle. Next cycle the load sits in WB and the select becomes 01.
- Store-data after an ALU op costs exactly 1 stall cycle, then `dest_forward_sel`=1.
- Reset asserted mid-stall or mid-freeze: the shadows clear immediately, and no stall is pending after release.

## Structure

- `lc3b_types` additions:
  - `lc3b_fwd_sel` enum {FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - `lc3b_hz_fields` packed struct {dest, regwrite, is_load}.
- Sub-module `fwd_match`: combinational three-way comparator returning `lc3b_fwd_sel` plus a mem_is_load flag. It is instantiated three times.
- Top level holds the shadow registers, the hazard OR, and the counter.

## Test plan

- ADD R1 then ADD R2,R1,R1 → sr1_sel=sr2_sel=10 in the consumer's EX cycle, `hz`=0, counter 0.
- ADD R1, NOP, ADD R3,R1,R4 → sr1_sel=01, sr2_sel=00.
- ADD R1, ADD R1, ADD R5,R1 → sr1_sel=10 (MEM wins over WB).
- LDR R1 then ADD R2,R1,R1 → one cycle of `stall_front`/`stall_ex`/`bubble_mem`=1 with sel 00, then sel 01; `hazard_stalls`=1.
- ADD R1 then STR R1,R6,#0 → one stall cycle, then `dest_forward_sel`=1.
- `mem_busy` high 3 cycles during a load-use hazard → `freeze`=1 and stalls 0 for 3 cycles, selects constant, counter unchanged. `rst_n` pulsed low mid-freeze → all outputs at reset values immediately.
